polirv_lsu: RTL and testbench

POLIRV_LSU -- requirements
Module: polirv_lsu

---
 rtl/polirv_lsu.sv | 145 ++++++++++++++
 tb/tb_polirv_lsu.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/polirv_lsu.sv
// Load/store unit: aligns core byte-addressed loads/stores onto a 64-bit
// doubleword memory, using read-modify-write for sub-doubleword stores.
module polirv_lsu #(
  parameter int D_ADDR_BITS = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  input  logic [D_ADDR_BITS+2:0] req_addr,
  input  logic [63:0]            req_wdata,
  output logic                   resp_valid,
  output logic                   resp_err,
  output logic [63:0]            resp_rdata,
  output logic [D_ADDR_BITS-1:0] d_mem_addr,
  output logic                   d_mem_we,
  output logic [63:0]            d_mem_wdata,
  input  logic [63:0]            d_mem_rdata
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] MRG  = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] RSP  = 3'd4;

  logic [2:0]  state_reg;
  logic [2:0]  off_reg;
  logic [1:0]  size_reg;
  logic        uns_reg;
  logic        we_reg;
  logic        err_reg;
  logic [63:0] wdata_reg;

  logic        misaligned;
  logic [7:0]  size_mask;
  logic [7:0]  byte_en;
  logic [63:0] wdata_shift;
  logic [63:0] rd_shift;
  logic [63:0] load_val;
  logic [63:0] merged;
  logic        sx;

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      default: misaligned = |req_addr[2:0];
    endcase
  end

  always_comb begin
    size_mask = 8'hFF;
    case (size_reg)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

  assign byte_en     = size_mask << off_reg;
  assign wdata_shift = wdata_reg << {off_reg, 3'b000};
  assign rd_shift    = d_mem_rdata >> {off_reg, 3'b000};
  assign sx          = ~uns_reg;

  always_comb begin
    load_val = rd_shift;
    case (size_reg)
      2'd0:    load_val = {{56{sx & rd_shift[7]}}, rd_shift[7:0]};
      2'd1:    load_val = {{48{sx & rd_shift[15]}}, rd_shift[15:0]};
      2'd2:    load_val = {{32{sx & rd_shift[31]}}, rd_shift[31:0]};
      default: load_val = rd_shift;
    endcase
  end

  // Addressed bytes take the shifted store data, the rest keep the memory word.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_merge
      assign merged[gi*8 +: 8] = byte_en[gi] ? wdata_shift[gi*8 +: 8] : d_mem_rdata[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      off_reg     <= '0;
      size_reg    <= '0;
      uns_reg     <= 1'b0;
      we_reg      <= 1'b0;
      err_reg     <= 1'b0;
      wdata_reg   <= '0;
      d_mem_addr  <= '0;
      d_mem_wdata <= '0;
      resp_rdata  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            off_reg    <= req_addr[2:0];
            size_reg   <= req_size;
            uns_reg    <= req_unsigned;
            we_reg     <= req_we;
            err_reg    <= misaligned;
            wdata_reg  <= req_wdata;
            d_mem_addr <= req_addr[D_ADDR_BITS+2:3];
            resp_rdata <= '0;
            if (misaligned) begin
              state_reg <= RSP;
            end else if (req_we && req_size == 2'd3) begin
              d_mem_wdata <= req_wdata;
              state_reg   <= WR;
            end else begin
              state_reg <= RD;
            end
          end
        end
        RD:  state_reg <= MRG;
        MRG: begin
          if (we_reg) begin
            d_mem_wdata <= merged;
            state_reg   <= WR;
          end else begin
            resp_rdata <= load_val;
            state_reg  <= RSP;
          end
        end
        WR:      state_reg <= RSP;
        RSP:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_reg == IDLE);
  assign resp_valid = (state_reg == RSP);
  assign resp_err   = resp_valid & err_reg;
  assign d_mem_we   = (state_reg == WR);

endmodule

// File: tb/tb_polirv_lsu.sv
// Bench for polirv_lsu: per-transaction expected cycle sequences from a
// byte-level memory model, checked every cycle, plus literal scenario checks.
module tb_polirv_lsu;
  localparam int DA = 6;
  localparam int AW = DA + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = '0;
  logic          req_unsigned = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [63:0]   req_wdata = '0;
  logic          resp_valid;
  logic          resp_err;
  logic [63:0]   resp_rdata;
  logic [DA-1:0] d_mem_addr;
  logic          d_mem_we;
  logic [63:0]   d_mem_wdata;
  logic [63:0]   d_mem_rdata;

  polirv_lsu #(.D_ADDR_BITS(DA)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_err(resp_err), .resp_rdata(resp_rdata), .d_mem_addr(d_mem_addr),
    .d_mem_we(d_mem_we), .d_mem_wdata(d_mem_wdata), .d_mem_rdata(d_mem_rdata)
  );

  always #5 clk = ~clk;

  // Physical memory the DUT talks to: synchronous read, one-cycle latency.
  logic [63:0] mem [64];
  logic [63:0] ref_mem [64];
  always @(posedge clk) begin
    if (d_mem_we) mem[d_mem_addr] <= d_mem_wdata;
    d_mem_rdata <= mem[d_mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          rv;
    logic          err;
    logic          we;
    logic [63:0]   rdata;
    logic [63:0]   wdata;
    logic [DA-1:0] addr;
  } exp_t;
  exp_t expq[$];

  int checks = 0;
  int errors = 0;
  bit skip = 1'b0;
  int accept_cyc = 0;
  int resp_lat = 0;
  int we_lat = 0;
  logic [63:0] last_rdata = '0;
  logic [63:0] last_wdata = '0;
  logic [DA-1:0] last_waddr = '0;
  logic last_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every cycle outside reset: busy cycles follow the expected sequence, otherwise idle.
  always @(negedge clk) begin
    if (!rst && !skip) begin
      if (expq.size() > 0) begin
        exp_t e;
        e = expq.pop_front();
        chk("busy_ready", {63'd0, req_ready}, 64'd0);
        chk("resp_valid", {63'd0, resp_valid}, {63'd0, e.rv});
        chk("mem_we", {63'd0, d_mem_we}, {63'd0, e.we});
        chk("mem_addr", {58'd0, d_mem_addr}, {58'd0, e.addr});
        if (e.rv) begin
          chk("resp_err", {63'd0, resp_err}, {63'd0, e.err});
          chk("resp_rdata", resp_rdata, e.rdata);
          last_rdata = resp_rdata;
          last_err = resp_err;
          resp_lat = cyc - accept_cyc + 1;
        end
        if (e.we) begin
          chk("mem_wdata", d_mem_wdata, e.wdata);
          last_wdata = d_mem_wdata;
          last_waddr = d_mem_addr;
          we_lat = cyc - accept_cyc + 1;
        end
      end else begin
        chk("idle_ready", {63'd0, req_ready}, 64'd1);
        chk("idle_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("idle_mem_we", {63'd0, d_mem_we}, 64'd0);
      end
    end
  end

  // Reference: what each accepted request must look like, cycle by cycle.
  task automatic model_push(input logic we, input logic [1:0] size, input logic uns,
                            input logic [AW-1:0] addr, input logic [63:0] wdata);
    int off;
    int nb;
    logic [DA-1:0] wa;
    logic [63:0] w;
    logic [63:0] v;
    exp_t busy;
    exp_t fin;
    exp_t wr;
    off = int'(addr[2:0]);
    nb = 1 << size;
    wa = addr[AW-1:3];
    busy = '{rv: 1'b0, err: 1'b0, we: 1'b0, rdata: 64'd0, wdata: 64'd0, addr: wa};
    fin = busy;
    fin.rv = 1'b1;
    if (off % nb != 0) begin
      fin.err = 1'b1;
      expq.push_back(fin);
    end else if (!we) begin
      w = ref_mem[wa];
      v = '0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = w[8*(off+i) +: 8];
      if (!uns && nb < 8 && v[8*nb-1])
        for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
      fin.rdata = v;
      expq.push_back(busy);
      expq.push_back(busy);
      expq.push_back(fin);
    end else begin
      w = ref_mem[wa];
      for (int i = 0; i < nb; i++) w[8*(off+i) +: 8] = wdata[8*i +: 8];
      ref_mem[wa] = w;
      wr = busy;
      wr.we = 1'b1;
      wr.wdata = w;
      if (nb < 8) begin
        expq.push_back(busy);
        expq.push_back(busy);
      end
      expq.push_back(wr);
      expq.push_back(fin);
    end
  endtask

  // Leaves req_valid high after acceptance; the next call or the caller changes it.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [AW-1:0] addr, input logic [63:0] wdata);
    int n;
    n = 0;
    @(negedge clk); #1;
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
    end else begin
      model_push(we, size, uns, addr, wdata);
      accept_cyc = cyc + 1;
      @(posedge clk);
    end
  endtask

  task automatic drop_valid();
    @(negedge clk); #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom); req_addr = AW'($urandom);
    req_wdata = {$urandom, $urandom};
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (expq.size() > 0 && n < 100) begin
      @(negedge clk); #2;
      n++;
    end
    if (expq.size() > 0) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_mem_we", {63'd0, d_mem_we}, 64'd0);
    chk("rst_mem_addr", {58'd0, d_mem_addr}, 64'd0);
    chk("rst_mem_wdata", d_mem_wdata, 64'd0);
  endtask

  initial begin
    int a1;
    logic [1:0] sz;
    logic [AW-1:0] ad;
    for (int i = 0; i < 64; i++) begin
      mem[i] = {$urandom, $urandom};
      ref_mem[i] = mem[i];
    end
    mem[2] = 64'h8877665544332211;
    ref_mem[2] = mem[2];

    #1;
    chk_reset_outputs();
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // Signed and unsigned byte load of the top byte of word 2.
    issue(1'b0, 2'd0, 1'b0, 9'h17, 64'd0);
    drop_valid();
    wait_idle();
    chk("lb_signed", last_rdata, 64'hFFFFFFFFFFFFFF88);
    chk("load_latency", resp_lat, 3);
    issue(1'b0, 2'd0, 1'b1, 9'h17, 64'd0);
    drop_valid();
    wait_idle();
    chk("lbu", last_rdata, 64'h0000000000000088);

    // Halfword read-modify-write store.
    issue(1'b1, 2'd1, 1'b0, 9'h12, 64'h000000000000BEEF);
    drop_valid();
    wait_idle();
    chk("sh_wdata", last_wdata, 64'h88776655BEEF2211);
    chk("sh_waddr", last_waddr, 2);
    chk("sh_we_latency", we_lat, 3);
    chk("sh_resp_latency", resp_lat, 4);

    // Doubleword store skips the read.
    issue(1'b1, 2'd3, 1'b0, 9'h08, 64'h0123456789ABCDEF);
    drop_valid();
    wait_idle();
    chk("sd_wdata", last_wdata, 64'h0123456789ABCDEF);
    chk("sd_waddr", last_waddr, 1);
    chk("sd_we_latency", we_lat, 1);
    chk("sd_resp_latency", resp_lat, 2);

    // Misaligned word load.
    issue(1'b0, 2'd2, 1'b0, 9'h12, 64'd0);
    drop_valid();
    wait_idle();
    chk("mis_err", last_err, 1);
    chk("mis_rdata", last_rdata, 0);
    chk("mis_latency", resp_lat, 1);

    // Reset during MRG of a byte store must abort it.
    skip = 1'b1;
    @(negedge clk); #1;
    req_we = 1'b1; req_size = 2'd0; req_addr = 9'h17; req_wdata = 64'h55; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    @(posedge clk); #1;
    chk("rst_hold_mem_we", {63'd0, d_mem_we}, 64'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    skip = 1'b0;
    chk("abort_mem_word", mem[2], 64'h88776655BEEF2211);
    issue(1'b0, 2'd3, 1'b0, 9'h10, 64'd0);
    drop_valid();
    wait_idle();
    chk("ld_after_abort", last_rdata, 64'h88776655BEEF2211);

    // Back-to-back loads with req_valid held high.
    issue(1'b0, 2'd1, 1'b0, 9'h0A, 64'd0);
    a1 = accept_cyc;
    issue(1'b0, 2'd2, 1'b1, 9'h14, 64'd0);
    chk("b2b_accept_gap", accept_cyc - a1, 4);
    drop_valid();
    wait_idle();

    // Randomized traffic, mostly aligned, occasionally back-to-back.
    for (int t = 0; t < 300; t++) begin
      sz = 2'($urandom);
      ad = AW'($urandom);
      if ($urandom_range(3, 0) != 0) ad = ad & ~(AW'((1 << sz) - 1));
      issue(1'($urandom), sz, 1'($urandom), ad, {$urandom, $urandom});
      if ($urandom_range(1, 0) == 0) begin
        drop_valid();
        repeat ($urandom_range(3, 0)) @(negedge clk);
      end
    end
    drop_valid();
    wait_idle();
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
